// File: rtl/encode_n.sv
// One-hot to binary encoder with registered index, valid and multi-hot error flags.
// The highest set bit wins when more than one input bit is asserted.
module encode_n #(
  parameter int n = 4,
  parameter int m = 1 << n
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [m-1:0] in,
  output logic [n-1:0] y,
  output logic         valid,
  output logic         err
);

  logic [n-1:0] y_d, y_q;
  logic         valid_d, valid_q;
  logic         err_d, err_q;

  always_comb begin
    y_d = '0;
    // Ascending scan: later (higher) set bits overwrite earlier ones, giving MSB priority.
    for (int k = 0; k < m; k++) begin
      if (in[k]) y_d = n'(k);
    end
    valid_d = |in;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    err_d   = |(in & (in - m'(1)));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_encode_n.sv
// Directed bench for encode_n: default n=4 instance plus an n=3 variant sharing clock and reset.
module tb_encode_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in16;
  logic [3:0]  y16;
  logic        valid16, err16;
  logic [7:0]  in8;
  logic [2:0]  y8;
  logic        valid8, err8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encode_n dut16 (
    .clk  (clk),
    .rst  (rst),
    .in   (in16),
    .y    (y16),
    .valid(valid16),
    .err  (err16)
  );

  encode_n #(.n(3), .m(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .in   (in8),
    .y    (y8),
    .valid(valid8),
    .err  (err8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect16(input string tag, input int ey, input bit ev, input bit ee);
    check({tag, ".y"},     32'(y16),     32'(ey));
    check({tag, ".valid"}, 32'(valid16), 32'(ev));
    check({tag, ".err"},   32'(err16),   32'(ee));
  endtask

  task automatic expect8(input string tag, input int ey, input bit ev, input bit ee);
    check({tag, ".y"},     32'(y8),     32'(ey));
    check({tag, ".valid"}, 32'(valid8), 32'(ev));
    check({tag, ".err"},   32'(err8),   32'(ee));
  endtask

  // Drive between edges, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic [15:0] v16, input logic [7:0] v8);
    @(negedge clk);
    in16 = v16;
    in8  = v8;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] v;
    int          ey;
    bit          ev;
    bit          ee;
    string       tag;
  } vec16_t;

  vec16_t vecs16[6];

  initial begin
    vecs16[0] = '{16'h0000, 0,  1'b0, 1'b0, "zero"};
    vecs16[1] = '{16'h0001, 0,  1'b1, 1'b0, "bit0"};
    vecs16[2] = '{16'h0081, 7,  1'b1, 1'b1, "multi81"};
    vecs16[3] = '{16'hFFFF, 15, 1'b1, 1'b1, "allones"};
    vecs16[4] = '{16'h0003, 1,  1'b1, 1'b1, "multi03"};
    vecs16[5] = '{16'h8000, 15, 1'b1, 1'b0, "bit15"};

    rst  = 1'b1;
    in16 = 16'h8000;
    in8  = 8'h80;
    #1;
    expect16("rst_imm", 0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      expect16("rst_hold", 0, 1'b0, 1'b0);
    end
    expect8("rst_hold8", 0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect16("rst_release", 15, 1'b1, 1'b0);
    expect8("rst_release8", 7, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(16'h8000 >> i, 8'h00);
      expect16($sformatf("walk16_%0d", 15 - i), 15 - i, 1'b1, 1'b0);
    end

    foreach (vecs16[i]) begin
      apply(vecs16[i].v, 8'h00);
      expect16(vecs16[i].tag, vecs16[i].ey, vecs16[i].ev, vecs16[i].ee);
    end

    // Short reset pulse between edges in the middle of a walk.
    for (int i = 0; i < 8; i++) begin
      apply(16'h8000 >> i, 8'h00);
      expect16($sformatf("walk_mid_%0d", 15 - i), 15 - i, 1'b1, 1'b0);
      if (i == 4) begin
        #1;
        rst = 1'b1;
        #1;
        expect16("pulse_clear", 0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        expect16("pulse_after", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect16("pulse_recover", 11, 1'b1, 1'b0);
      end
    end

    for (int i = 0; i < 8; i++) begin
      apply(16'h0000, 8'h80 >> i);
      expect8($sformatf("walk8_%0d", 7 - i), 7 - i, 1'b1, 1'b0);
    end
    apply(16'h0000, 8'h00);
    expect8("zero8", 0, 1'b0, 1'b0);
    apply(16'h0000, 8'h24);
    expect8("multi24", 5, 1'b1, 1'b1);
    apply(16'h0000, 8'hFF);
    expect8("allones8", 7, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
